// File: rtl/common_pkg.sv
// common: data bus request/response types shared with the memory system.
package common;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

// File: rtl/pipes_pkg.sv
// pipes: pipeline stage register types and memory access size encoding.
package pipes;
    typedef enum logic [1:0] {ALU, LOAD, STORE, BRANCH} op_t;
    typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
    typedef enum logic {IDLE, WAIT} mstate_t;

    typedef struct packed {
        op_t  op;
        logic wen;
    } ctl_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] rd2;
        logic [63:0] result;
    } excute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] result;
        logic        misalign;
    } memory_data_t;

    function automatic logic misaligned(msize_t size, logic [2:0] addr);
        return size == MSIZE2 ? addr[0] != 1'b0 :
               size == MSIZE4 ? addr[1:0] != 2'b00 :
               size == MSIZE8 ? addr != 3'b000 : 1'b0;
    endfunction
endpackage

// File: rtl/memory_memalign.sv
// memalign: byte-lane alignment of store data/strobe and load extract/extend.
module memalign (
    input  logic [2:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  strobe_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o
);
    logic [63:0] sh;
    logic [7:0]  mask;
    logic        sx;

    always_comb begin
        mask     = funct3_i[1:0] == 2'd0 ? 8'h01 :
                   funct3_i[1:0] == 2'd1 ? 8'h03 :
                   funct3_i[1:0] == 2'd2 ? 8'h0F : 8'hFF;
        strobe_o = mask << addr_i;
        wdata_o  = wdata_i << {addr_i, 3'b000};
        sh       = rdata_i >> {addr_i, 3'b000};
        sx       = !funct3_i[2];
        rdata_o  = funct3_i[1:0] == 2'd0 ? {{56{sx & sh[7]}}, sh[7:0]} :
                   funct3_i[1:0] == 2'd1 ? {{48{sx & sh[15]}}, sh[15:0]} :
                   funct3_i[1:0] == 2'd2 ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
    end
endmodule

// File: rtl/memory.sv
// memory: memory stage; issues data bus requests, stalls execute until data_ok.
module memory
    import pipes::*;
    import common::*;
(
    input  logic         clk,
    input  logic         reset,
    input  excute_data_t dataE,
    output memory_data_t dataM,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp,
    output logic         stopm
);
    logic [2:0]   f3;
    msize_t       msize;
    logic         mem_op, is_store, mis, issue;
    logic [7:0]   strobe;
    logic [63:0]  wdata, rdata;
    dbus_req_t    req_d, req_q;
    mstate_t      state_d, state_q;
    memory_data_t dataM_d, dataM_q;
    logic         unused_addr_ok;

    assign unused_addr_ok = dresp.addr_ok;

    memalign u_align (
        .addr_i   (dataE.result[2:0]),
        .funct3_i (f3),
        .wdata_i  (dataE.rd2),
        .rdata_i  (dresp.data),
        .strobe_o (strobe),
        .wdata_o  (wdata),
        .rdata_o  (rdata)
    );

    always_comb begin
        f3           = dataE.instr[14:12];
        msize        = msize_t'({1'b0, f3[1:0]});
        mem_op       = dataE.valid && (dataE.ctl.op == LOAD || dataE.ctl.op == STORE);
        is_store     = dataE.ctl.op == STORE;
        mis          = mem_op && misaligned(msize, dataE.result[2:0]);
        issue        = mem_op && !mis;
        req_d        = '0;
        req_d.valid  = issue;
        req_d.addr   = dataE.result;
        req_d.size   = msize;
        req_d.strobe = is_store ? strobe : 8'h00;
        req_d.data   = wdata;
        // the request captured on entering WAIT is replayed so the bus sees it unchanged
        dreq         = state_q == WAIT ? req_q : req_d;
        dreq.valid   = dreq.valid && reset;
        stopm        = dreq.valid && !dresp.data_ok;
        state_d      = stopm ? WAIT : IDLE;
        dataM_d          = '0;
        dataM_d.valid    = dataE.valid && !stopm;
        dataM_d.pc       = dataE.pc;
        dataM_d.instr    = dataE.instr;
        dataM_d.ctl      = dataE.ctl;
        dataM_d.dst      = dataE.dst;
        dataM_d.result   = issue && !is_store ? rdata : dataE.result;
        dataM_d.misalign = mis;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dataM_q <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            dataM_q <= dataM_d;
            if (state_q == IDLE) req_q <= req_d;
        end
    end

    assign dataM = dataM_q;
endmodule

// File: tb/tb_memory.sv
// tb_memory: randomized and directed checks of the memory stage against a byte-level model.
module tb_memory;
    import pipes::*;
    import common::*;

    logic         clk = 1'b0;
    logic         reset;
    excute_data_t dataE;
    memory_data_t dataM;
    dbus_req_t    dreq;
    dbus_resp_t   dresp;
    logic         stopm;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    memory dut (
        .clk   (clk),
        .reset (reset),
        .dataE (dataE),
        .dataM (dataM),
        .dreq  (dreq),
        .dresp (dresp),
        .stopm (stopm)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nb(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit memop(excute_data_t d);
        return d.valid && (d.ctl.op == LOAD || d.ctl.op == STORE);
    endfunction

    function automatic bit misal(excute_data_t d);
        return memop(d) && (int'(d.result[2:0]) % nb(d.instr[14:12]) != 0);
    endfunction

    function automatic logic [63:0] load_val(logic [63:0] rdata, logic [2:0] a, logic [2:0] f3);
        logic [63:0] v = '0;
        int n = nb(f3);
        int ai = int'(a);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(ai+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] strobe_of(logic [2:0] a, logic [2:0] f3);
        logic [7:0] s = '0;
        for (int i = 0; i < nb(f3); i++) s[int'(a) + i] = 1'b1;
        return s;
    endfunction

    function automatic excute_data_t mk(bit v, op_t op, logic [2:0] f3, logic [63:0] res, logic [63:0] rd2);
        excute_data_t d = '0;
        d.valid         = v;
        d.pc            = 64'h8000_0000 + {32'b0, $urandom};
        d.instr[14:12]  = f3;
        d.instr[6:0]    = 7'($urandom);
        d.ctl.op        = op;
        d.ctl.wen       = 1'b1;
        d.dst           = 5'($urandom);
        d.rd2           = rd2;
        d.result        = res;
        return d;
    endfunction

    // one pipeline cycle: called at a falling edge with inputs already applied
    task automatic tick();
        bit issue, exp_v, exp_mis;
        logic [63:0] exp_res;
        #1;
        issue = memop(dataE) && !misal(dataE);
        chk("dreq.valid", dreq.valid, issue);
        chk("stopm", stopm, issue && !dresp.data_ok);
        if (issue) begin
            chk("dreq.addr", dreq.addr, dataE.result);
            chk("dreq.size", dreq.size, {1'b0, dataE.instr[13:12]});
            chk("dreq.strobe", dreq.strobe,
                dataE.ctl.op == STORE ? strobe_of(dataE.result[2:0], dataE.instr[14:12]) : 8'h00);
            if (dataE.ctl.op == STORE) chk("dreq.data", dreq.data, dataE.rd2 << (8 * dataE.result[2:0]));
        end
        exp_v   = dataE.valid && !(issue && !dresp.data_ok);
        exp_mis = misal(dataE);
        exp_res = issue && dataE.ctl.op == LOAD ?
                  load_val(dresp.data, dataE.result[2:0], dataE.instr[14:12]) : dataE.result;
        @(posedge clk);
        #1;
        chk("dataM.valid", dataM.valid, exp_v);
        if (exp_v) begin
            chk("dataM.result", dataM.result, exp_res);
            chk("dataM.misalign", dataM.misalign, exp_mis);
            chk("dataM.pc", dataM.pc, dataE.pc);
            chk("dataM.dst", dataM.dst, dataE.dst);
        end
        @(negedge clk);
    endtask

    initial begin
        dbus_req_t snap;
        int stall, k, lat, r;
        bit hold, issue;
        reset = 1'b0;
        dataE = mk(0, ALU, 3'd0, 64'h0, 64'h0);
        dresp = '0;
        repeat (2) @(negedge clk);
        chk("reset dataM.valid", dataM.valid, 1'b0);
        chk("reset dataM.misalign", dataM.misalign, 1'b0);
        chk("reset dreq.valid", dreq.valid, 1'b0);
        reset = 1'b1;

        dataE = mk(1, ALU, 3'd0, 64'h1234, 64'h0);
        tick();
        chk("add result", dataM.result, 64'h1234);
        chk("add valid", dataM.valid, 1'b1);

        dataE = mk(1, LOAD, 3'd0, 64'h1003, 64'h0);
        stall = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stopm) stall++;
            if (i == 0) snap = dreq;
            else chk("lb dreq stable", 64'(dreq != snap), 64'd0);
            tick();
        end
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h00000000_80000000;
        tick();
        chk("lb stall cycles", stall, 3);
        chk("lb result", dataM.result, 64'hFFFFFFFF_FFFFFF80);

        dataE = mk(1, STORE, 3'd1, 64'h1006, 64'hBEEF);
        #1;
        chk("sh strobe", dreq.strobe, 8'hC0);
        chk("sh data", dreq.data, 64'hBEEF000000000000);
        chk("sh stopm", stopm, 1'b0);
        tick();

        dresp.data_ok = 1'b0;
        dataE = mk(1, LOAD, 3'd2, 64'h1002, 64'h0);
        #1;
        chk("lw mis dreq.valid", dreq.valid, 1'b0);
        tick();
        chk("lw misalign", dataM.misalign, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async dataM.valid", dataM.valid, 1'b0);
        chk("async misalign", dataM.misalign, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        dresp.data_ok = 1'b1;
        dresp.data    = 64'hF0000000_00000000;
        dataE = mk(1, LOAD, 3'd6, 64'h1004, 64'h0);
        tick();
        chk("lwu result", dataM.result, 64'h00000000_F0000000);

        dresp.data_ok = 1'b0;
        dataE = mk(1, LOAD, 3'd3, 64'h1008, 64'h0);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("wait reset dreq.valid", dreq.valid, 1'b0);
        chk("wait reset stopm", stopm, 1'b0);
        chk("wait reset dataM.valid", dataM.valid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        dataE = mk(1, LOAD, 3'd3, 64'h2010, 64'h0);
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h0123456789ABCDEF;
        #1;
        chk("post reset addr", dreq.addr, 64'h2010);
        tick();
        chk("post reset ld", dataM.result, 64'h0123456789ABCDEF);

        hold = 0;
        k = 0;
        lat = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                r = $urandom_range(0, 9);
                dataE = r < 2 ? mk(0, op_t'($urandom_range(0, 3)), 3'($urandom_range(0, 6)), {$urandom, $urandom}, {$urandom, $urandom}) :
                        r < 4 ? mk(1, ALU, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}) :
                        r < 7 ? mk(1, LOAD, 3'($urandom_range(0, 6)), {$urandom, $urandom}, {$urandom, $urandom}) :
                                mk(1, STORE, 3'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
                lat = $urandom_range(0, 3);
                k = 0;
            end
            issue = memop(dataE) && !misal(dataE);
            dresp.addr_ok = 1'($urandom);
            dresp.data    = {$urandom, $urandom};
            dresp.data_ok = issue ? (k == lat) : 1'($urandom);
            tick();
            if (issue && k < lat) begin
                hold = 1;
                k++;
            end else hold = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
